// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures regfile data, decoded control and fields at end of ID.
// Latency: 1 cycle from ID inputs to ex_* outputs; stall/bypass paths are combinational.
// Backpressure: hold freezes every register; load-use stall inserts one bubble upstream-frozen.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset (0 = reset)
//   id_*                ID-stage instruction: valid, rs/rt/rd/imm fields, rt-use flag,
//                       regfile read data A/B, 9-bit control
//                       {regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, aluop[1:0]}
//   wb_regwrite/rd/writedata   same-cycle regfile write, bypassed into the captured operands
//   flush               branch taken: replace the ID instruction with a bubble
//   hold                downstream stall: freeze this stage entirely
//   stall               load-use hazard: PC and IF/ID must freeze this cycle
//   ex_*                registered outputs to EX (ex_dst = regdst ? rd : rt)
//   bubble_cnt          saturating count of load-use bubbles inserted
module id_ex_stage #(
   parameter int DW   = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [4:0]      id_rs,
   input  logic [4:0]      id_rt,
   input  logic [4:0]      id_rd,
   input  logic [15:0]     id_imm,
   input  logic            id_uses_rt,
   input  logic [DW-1:0]   id_readdat1,
   input  logic [DW-1:0]   id_readdat2,
   input  logic [8:0]      id_ctrl,
   input  logic            wb_regwrite,
   input  logic [4:0]      wb_rd,
   input  logic [DW-1:0]   wb_writedata,
   input  logic            flush,
   input  logic            hold,
   output logic            stall,
   output logic            ex_valid,
   output logic [8:0]      ex_ctrl,
   output logic [DW-1:0]   ex_a,
   output logic [DW-1:0]   ex_b,
   output logic [DW-1:0]   ex_imm,
   output logic [4:0]      ex_rs,
   output logic [4:0]      ex_rt,
   output logic [4:0]      ex_dst,
   output logic [CNTW-1:0] bubble_cnt
);

   // Control bit positions within the 9-bit control word.
   localparam int MEMREAD_BIT = 7;
   localparam int REGDST_BIT  = 3;

   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   logic          hazard;
   logic          wb_hit_a;
   logic          wb_hit_b;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [DW-1:0] imm_ext;
   logic [4:0]    dst_sel;

   // A load in EX whose target is read by the ID instruction; $0 never hazards.
   always_comb begin
      hazard = ex_valid && ex_ctrl[MEMREAD_BIT] && (ex_rt != 5'd0) && id_valid &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   end

   // A flushed ID instruction is discarded, so it cannot hold the front end.
   assign stall = hazard && !flush;

   // The regfile writes at the clock edge, so same-cycle WB data is bypassed here.
   always_comb begin
      wb_hit_a = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs);
      wb_hit_b = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rt);
      op_a     = wb_hit_a ? wb_writedata : id_readdat1;
      op_b     = wb_hit_b ? wb_writedata : id_readdat2;
      imm_ext  = {{(DW-16){id_imm[15]}}, id_imm};
      dst_sel  = id_ctrl[REGDST_BIT] ? id_rd : id_rt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_a       <= '0;
         ex_b       <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_dst     <= '0;
         bubble_cnt <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_imm   <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_dst   <= '0;
      end else if (hold) begin
         // Freeze: a pending hazard is re-evaluated once hold drops, so the bubble
         // is only counted on the edge that actually inserts it.
      end else if (hazard) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_imm   <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_dst   <= '0;
         if (bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
         end
      end else begin
         ex_valid <= id_valid;
         ex_ctrl  <= id_valid ? id_ctrl : 9'd0;
         ex_a     <= op_a;
         ex_b     <= op_b;
         ex_imm   <= imm_ext;
         ex_rs    <= id_rs;
         ex_rt    <= id_rt;
         ex_dst   <= dst_sel;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [4:0]    id_rs, id_rt, id_rd;
   logic [15:0]   id_imm;
   logic          id_uses_rt;
   logic [DW-1:0] id_readdat1, id_readdat2;
   logic [8:0]    id_ctrl;
   logic          wb_regwrite;
   logic [4:0]    wb_rd;
   logic [DW-1:0] wb_writedata;
   logic          flush, hold;

   logic          stall, ex_valid;
   logic [8:0]    ex_ctrl;
   logic [DW-1:0] ex_a, ex_b, ex_imm;
   logic [4:0]    ex_rs, ex_rt, ex_dst;
   logic [15:0]   bubble_cnt;

   // Second instance with a 2-bit counter to exercise saturation.
   logic          stall_s, ex_valid_s;
   logic [8:0]    ex_ctrl_s;
   logic [DW-1:0] ex_a_s, ex_b_s, ex_imm_s;
   logic [4:0]    ex_rs_s, ex_rt_s, ex_dst_s;
   logic [1:0]    bubble_cnt_s;

   always #5 clk = ~clk;

   id_ex_stage #(.DW(DW), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_imm(id_imm), .id_uses_rt(id_uses_rt),
      .id_readdat1(id_readdat1), .id_readdat2(id_readdat2), .id_ctrl(id_ctrl),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_writedata(wb_writedata),
      .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
      .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .bubble_cnt(bubble_cnt)
   );

   id_ex_stage #(.DW(DW), .CNTW(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_imm(id_imm), .id_uses_rt(id_uses_rt),
      .id_readdat1(id_readdat1), .id_readdat2(id_readdat2), .id_ctrl(id_ctrl),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_writedata(wb_writedata),
      .flush(flush), .hold(hold), .stall(stall_s), .ex_valid(ex_valid_s),
      .ex_ctrl(ex_ctrl_s), .ex_a(ex_a_s), .ex_b(ex_b_s), .ex_imm(ex_imm_s),
      .ex_rs(ex_rs_s), .ex_rt(ex_rt_s), .ex_dst(ex_dst_s), .bubble_cnt(bubble_cnt_s)
   );

   typedef struct packed {
      logic          valid;
      logic [8:0]    ctrl;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] imm;
      logic [4:0]    rs;
      logic [4:0]    rt;
      logic [4:0]    dst;
      logic [15:0]   cnt;
      logic [1:0]    cnt2;
   } exp_t;

   localparam logic [8:0] CTRL_LW  = 9'h1B0; // regwrite, memread, memtoreg, alusrc
   localparam logic [8:0] CTRL_ADD = 9'h10A; // regwrite, regdst, aluop=10

   exp_t m;          // reference model of the stage registers
   exp_t sb[$];      // expected post-edge state, pushed at drive time
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic model_stall();
      logic hz;
      hz = m.valid && m.ctrl[7] && (m.rt != 5'd0) && id_valid &&
           ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
      return hz && !flush;
   endfunction

   function automatic exp_t bubble_of(input exp_t c);
      exp_t r;
      r      = '0;
      r.cnt  = c.cnt;
      r.cnt2 = c.cnt2;
      return r;
   endfunction

   task automatic idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0; id_uses_rt = 0;
      id_readdat1 = 0; id_readdat2 = 0; id_ctrl = 0;
      wb_regwrite = 0; wb_rd = 0; wb_writedata = 0; flush = 0; hold = 0;
   endtask

   task automatic set_id(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ur);
      id_valid = 1; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur;
      id_readdat1 = 32'h1000 + 32'(rs); id_readdat2 = 32'h2000 + 32'(rt);
      id_imm = {11'd0, rd};
   endtask

   // Drive is already applied; check stall, predict, clock, then compare.
   task automatic step(input string tag);
      exp_t n, e;
      logic st;
      #1;
      st = model_stall();
      chk({tag, "_stall"}, 128'(stall), 128'(st));
      n = m;
      if (!rst) begin
         n = '0;
      end else if (flush) begin
         n = bubble_of(m);
      end else if (hold) begin
         n = m;
      end else if (st) begin
         n = bubble_of(m);
         if (m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
         if (m.cnt2 != 2'b11) n.cnt2 = m.cnt2 + 2'd1;
      end else begin
         n.valid = id_valid;
         n.ctrl  = id_valid ? id_ctrl : 9'd0;
         n.a     = (wb_regwrite && wb_rd != 0 && wb_rd == id_rs) ? wb_writedata : id_readdat1;
         n.b     = (wb_regwrite && wb_rd != 0 && wb_rd == id_rt) ? wb_writedata : id_readdat2;
         n.imm   = {{16{id_imm[15]}}, id_imm};
         n.rs    = id_rs;
         n.rt    = id_rt;
         n.dst   = id_ctrl[3] ? id_rd : id_rt;
      end
      sb.push_back(n);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      m = e;
      chk({tag, "_main"},
          {ex_valid, ex_ctrl, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dst, bubble_cnt},
          {e.valid, e.ctrl, e.a, e.b, e.imm, e.rs, e.rt, e.dst, e.cnt});
      chk({tag, "_sat"},
          {stall_s, ex_valid_s, ex_ctrl_s, ex_a_s, ex_b_s, ex_imm_s, ex_rs_s, ex_rt_s, ex_dst_s, bubble_cnt_s},
          {model_stall(), e.valid, e.ctrl, e.a, e.b, e.imm, e.rs, e.rt, e.dst, e.cnt2});
   endtask

   initial begin
      rst = 0;
      idle();
      m = '0;

      // Reset with random inputs: all outputs zero, asynchronously.
      #2;
      id_valid = 1; id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      id_imm = 16'($urandom); id_readdat1 = $urandom; id_readdat2 = $urandom;
      id_ctrl = 9'($urandom); wb_regwrite = 1; wb_rd = 5'($urandom); wb_writedata = $urandom;
      step("rst0");
      step("rst1");
      chk("rst_stall", 128'(stall), 128'(0));
      chk("rst_cnt", 128'(bubble_cnt), 128'(0));

      // Release and load a first instruction.
      rst = 1;
      idle();
      id_valid = 1; id_readdat1 = 32'h11;
      step("rel");
      chk("rel_a", 128'(ex_a), 128'(32'h11));

      // WB bypass on both operands, then $0 never bypassed.
      idle();
      id_valid = 1; id_ctrl = CTRL_ADD; id_rs = 5; id_rt = 5;
      id_readdat1 = 32'hAAAA; id_readdat2 = 32'hBBBB;
      wb_regwrite = 1; wb_rd = 5; wb_writedata = 32'h1234;
      step("byp");
      chk("byp_a", 128'(ex_a), 128'(32'h1234));
      chk("byp_b", 128'(ex_b), 128'(32'h1234));
      wb_rd = 0; id_rs = 0;
      step("byp0");
      chk("byp0_a", 128'(ex_a), 128'(32'hAAAA));

      // Load-use: lw rt=8 in EX, add rs=8 in ID.
      idle();
      set_id(CTRL_LW, 5'd2, 5'd8, 5'd0, 1'b0);
      step("lu_lw");
      set_id(CTRL_ADD, 5'd8, 5'd4, 5'd10, 1'b1);
      #1;
      chk("lu_stall", 128'(stall), 128'(1));
      step("lu_bub");
      chk("lu_bub", 128'({ex_valid, ex_ctrl, bubble_cnt}), 128'({1'b0, 9'd0, 16'd1}));
      step("lu_add");
      chk("lu_add", 128'({stall, ex_valid, ex_ctrl}), 128'({1'b0, 1'b1, CTRL_ADD}));

      // rt matches but is not a source: no hazard.
      set_id(CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b0);
      step("nu_lw");
      set_id(CTRL_ADD, 5'd3, 5'd9, 5'd11, 1'b0);
      step("nu_add");
      chk("nu_cnt", 128'({ex_valid, bubble_cnt}), 128'({1'b1, 16'd1}));

      // Flush beats hold and stall.
      set_id(CTRL_LW, 5'd2, 5'd8, 5'd0, 1'b0);
      step("fl_lw");
      set_id(CTRL_ADD, 5'd8, 5'd8, 5'd10, 1'b1);
      flush = 1; hold = 1;
      step("fl");
      chk("fl_state", 128'({ex_valid, bubble_cnt}), 128'({1'b0, 16'd1}));
      flush = 0; hold = 0;

      // Immediate sign extension and regdst destination, then 3 held cycles.
      set_id(CTRL_ADD, 5'd1, 5'd7, 5'd12, 1'b1);
      id_imm = 16'h8001;
      step("imm");
      chk("imm_ext", 128'(ex_imm), 128'(32'hFFFF8001));
      chk("imm_dst", 128'(ex_dst), 128'(12));
      hold = 1;
      set_id(CTRL_LW, 5'd20, 5'd21, 5'd22, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step("hold");
         chk("hold_imm", 128'({ex_imm, ex_dst}), 128'({32'hFFFF8001, 5'd12}));
      end
      hold = 0;

      // Hold during a load-use hazard: stall stays up, counted once.
      set_id(CTRL_LW, 5'd2, 5'd8, 5'd0, 1'b0);
      step("hs_lw");
      set_id(CTRL_ADD, 5'd8, 5'd4, 5'd10, 1'b1);
      hold = 1;
      step("hs_h1");
      step("hs_h2");
      chk("hs_cnt_held", 128'({stall, bubble_cnt}), 128'({1'b1, 16'd1}));
      hold = 0;
      step("hs_bub");
      chk("hs_cnt", 128'(bubble_cnt), 128'(2));
      step("hs_add");

      // Five more bubbles: 16-bit counter reaches 7, 2-bit one saturates at 3.
      for (int i = 0; i < 5; i++) begin
         set_id(CTRL_LW, 5'd2, 5'd8, 5'd0, 1'b0);
         step("sat_lw");
         set_id(CTRL_ADD, 5'd8, 5'd4, 5'd10, 1'b1);
         step("sat_bub");
      end
      chk("sat_cnt16", 128'(bubble_cnt), 128'(7));
      chk("sat_cnt2", 128'(bubble_cnt_s), 128'(3));

      // Mid-stream asynchronous reset, then a normal load after release.
      set_id(CTRL_ADD, 5'd5, 5'd6, 5'd7, 1'b1);
      step("mr_load");
      #2;
      rst = 0;
      #1;
      chk("mr_async", 128'({ex_valid, ex_ctrl, ex_a, bubble_cnt, bubble_cnt_s}), 128'(0));
      m = '0;
      @(posedge clk);
      #1;
      rst = 1;
      set_id(CTRL_ADD, 5'd5, 5'd6, 5'd7, 1'b1);
      step("mr_rel");
      chk("mr_rel_valid", 128'({ex_valid, ex_a}), 128'({1'b1, 32'h1005}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, directly downstream of the register file.
- Captures the register-file read data, decoded control and instruction fields at the end of ID, and presents them registered to EX.
- Provides write-back bypass for a same-cycle regfile write, load-use hazard detection with bubble insertion, branch flush, external hold, and a saturating bubble counter.

Parameters:
- DW, 32, datapath width
- CNTW, 16, width of load-use bubble counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  source register 1 field
- id_rt  in  5  source register 2 field
- id_rd  in  5  destination field (R-type)
- id_imm  in  16  immediate field
- id_uses_rt  in  1  instruction reads rt as a source
- id_readdat1  in  DW  regfile port A data
- id_readdat2  in  DW  regfile port B data
- id_ctrl  in  9  {regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, aluop[1:0]}
- wb_regwrite  in  1  WB stage writes the regfile this cycle
- wb_rd  in  5  WB destination register
- wb_writedata  in  DW  WB write data
- flush  in  1  branch taken; kill the ID instruction
- hold  in  1  downstream stall; freeze this register
- stall  out  1  load-use hazard; freeze PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  9  registered control
- ex_a  out  DW  operand A
- ex_b  out  DW  operand B (register value)
- ex_imm  out  DW  sign-extended immediate
- ex_rs, ex_rt  out  5  each  registered source fields (for the forwarding unit)
- ex_dst  out  5  regdst ? rd : rt
- bubble_cnt  out  CNTW  count of load-use bubbles inserted

Behaviour:
- Reset (rst=0, asynchronous): every output register is 0, including ex_valid, ex_ctrl, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dst and bubble_cnt. stall is combinational and therefore 0, because ex_valid=0.
- Hazard detection (combinational):
  - stall = ex_valid & ex_ctrl.memread & ex_rt!=0 & id_valid & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - stall is forced to 0 while flush=1.
- WB bypass (combinational, before capture):
  - A = (wb_regwrite & wb_rd!=0 & wb_rd==id_rs) ? wb_writedata : id_readdat1.
  - B uses the same rule with id_rt and id_readdat2.
  - Register 0 is never bypassed.
- Immediate: ex_imm = {16 copies of id_imm[15], id_imm}.
- Per-edge update priority, highest first:
  1. flush: load a bubble.
  2. hold: all registers keep their values, including bubble_cnt.
  3. stall: load a bubble and increment bubble_cnt.
  4. Otherwise: load ID values with ex_valid=id_valid. If id_valid=0, ex_ctrl is loaded as 0.
- Bubble: ex_valid=0, ex_ctrl=0. Data and field registers are loaded as 0.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs.
- bubble_cnt saturates at all-ones and does not wrap. It counts once per bubble-inserting edge.
- A stall lasts exactly 1 cycle for one load: after the bubble ex_valid=0, so stall drops. hold extends it without double-counting.
- Reset asserted mid-stream clears everything immediately. The first edge after release loads normally.

Test Plan:
- Reset: drive rst=0 with random inputs -> all ex_* = 0, bubble_cnt = 0, stall = 0. Release rst; id_readdat1=32'h11, id_valid=1 -> ex_a=32'h11 after one edge.
- Bypass:
  - id_rs=5, id_readdat1=32'hAAAA, wb_regwrite=1, wb_rd=5, wb_writedata=32'h1234 -> ex_a=32'h1234.
  - Same stimulus with wb_rd=0 and id_rs=0 -> ex_a=id_readdat1.
- Load-use: lw writes rt=8 and sits in EX; ID has add with rs=8 -> stall=1 that cycle. Next edge: ex_valid=0, ex_ctrl=0, bubble_cnt=1. Following edge: add is captured, stall=0.
- Non-use rt: EX lw with rt=9; ID rt=9 with id_uses_rt=0 and rs=3 -> stall=0, no bubble.
- Flush vs stall/hold: flush=1, hold=1 and a load-use condition together -> stall=0. Next edge: ex_valid=0, bubble_cnt unchanged. Then hold=1 alone for 3 cycles -> ex_* frozen.
- Immediate and counter:
  - id_imm=16'h8001 -> ex_imm=32'hFFFF8001.
  - regdst=1, rd=12, rt=7 -> ex_dst=12.
  - With CNTW=2, force 5 load-use bubbles -> bubble_cnt=3 (saturated).
